// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer helpers for the synchronous FIFO.
// The pointers carry one extra wrap bit above the memory address.
package sync_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 128;
    localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

    // Same address with opposite wrap bits means the writer is a full lap ahead.
    function automatic logic ptr_full(input logic [DEF_ADDR_W:0] wr_ptr,
                                      input logic [DEF_ADDR_W:0] rd_ptr);
        return (wr_ptr[DEF_ADDR_W-1:0] == rd_ptr[DEF_ADDR_W-1:0]) &&
               (wr_ptr[DEF_ADDR_W] != rd_ptr[DEF_ADDR_W]);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one write port and one registered read port.
// Only the output register is reset; the array itself is never cleared.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: a same-address read on a write edge returns the old word.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem_reg[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointer, flag and accept logic around a fifo_mem instance.
// Flags are decoded from the registered pointers only, never from wrtEn/rdEn.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              wrtEn,
    input  logic              rdEn,
    input  logic [DATA_W-1:0] wrtData,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] rdData
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic             wr_accept;
    logic             rd_accept;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                   (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);

    // A full FIFO still takes a write when a read frees the slot on the same edge.
    assign rd_accept = rdEn && !empty;
    assign wr_accept = wrtEn && (!full || rd_accept);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (rd_accept) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst_    (rst_),
        .wr_en   (wr_accept && rst_),
        .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
        .wr_data (wrtData),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
        .rd_data (rdData)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed scenarios plus randomized traffic, checked
// against a queue-based reference model after every clock edge.
module tb_sync_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 128;

    logic              clk = 1'b0;
    logic              rst_;
    logic              wrtEn;
    logic              rdEn;
    logic [DATA_W-1:0] wrtData;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] rdData;

    int n_vec = 0;
    int n_err = 0;
    int n_cyc = 0;

    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] exp_rd;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_    (rst_),
        .wrtEn   (wrtEn),
        .rdEn    (rdEn),
        .wrtData (wrtData),
        .full    (full),
        .empty   (empty),
        .rdData  (rdData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, n_cyc);
        end
    endtask

    // One clock edge: drive inputs, advance the model, compare all outputs.
    task automatic step(input bit rstn, input bit we, input bit re, input logic [DATA_W-1:0] d,
                        input string tag);
        bit rd_acc, wr_acc;
        rst_    = rstn;
        wrtEn   = we;
        rdEn    = re;
        wrtData = d;
        rd_acc  = re && (model_q.size() > 0);
        wr_acc  = we && ((model_q.size() < DEPTH) || rd_acc);
        @(posedge clk);
        #1;
        n_cyc++;
        if (!rstn) begin
            model_q.delete();
            exp_rd = '0;
        end else begin
            if (rd_acc) exp_rd = model_q.pop_front();
            if (wr_acc) model_q.push_back(d);
        end
        $display("cyc %0d %s rst_=%0b we=%0b re=%0b d=%02h -> rd=%02h full=%0b empty=%0b occ=%0d",
                 n_cyc, tag, rstn, we, re, d, rdData, full, empty, model_q.size());
        check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(model_q.size() == DEPTH));
        check({tag, ".rdData"}, 32'(rdData), 32'(exp_rd));
    endtask

    initial begin
        int wp, rp;
        exp_rd = '0;
        rst_ = 1'b0; wrtEn = 1'b0; rdEn = 1'b0; wrtData = '0;

        // Reset held for one cycle, with requests active to show they are ignored
        step(0, 1, 1, 8'h33, "reset");

        // Fill 1..128, then a dropped 129th write
        for (int i = 1; i <= DEPTH; i++) step(1, 1, 0, DATA_W'(i), "fill");
        step(1, 1, 0, 8'hFF, "fill_drop");

        // Simultaneous read and write while full
        step(1, 1, 1, 8'hAA, "full_rw");
        check("full_rw.rd_is_1", 32'(rdData), 32'd1);

        // Drain everything; last word must be the 0xAA written at full
        for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 8'h00, "drain");
        check("drain.last_aa", 32'(rdData), 32'hAA);
        step(1, 0, 1, 8'h00, "drain_extra");
        check("drain_extra.hold", 32'(rdData), 32'hAA);

        // Empty with write and read on the same edge: read ignored
        step(1, 1, 1, 8'h55, "empty_rw");
        check("empty_rw.not_empty", 32'(empty), 32'd0);
        step(1, 0, 1, 8'h00, "empty_rw_rd");
        check("empty_rw_rd.val", 32'(rdData), 32'h55);

        // Write 100, read 100, write 100 to cross the pointer wrap
        for (int i = 0; i < 100; i++) step(1, 1, 0, DATA_W'(i + 16), "wrap_w1");
        for (int i = 0; i < 100; i++) step(1, 0, 1, 8'h00, "wrap_r");
        for (int i = 0; i < 100; i++) step(1, 1, 0, DATA_W'(i * 3), "wrap_w2");
        for (int i = 0; i < 40; i++)  step(1, 0, 1, 8'h00, "wrap_r2");

        // Mid-stream reset, then a write on the first edge out of reset
        step(0, 1, 1, 8'h77, "mid_reset");
        step(1, 1, 0, 8'h5A, "post_reset_w");
        step(1, 0, 1, 8'h00, "post_reset_r");
        check("post_reset_r.val", 32'(rdData), 32'h5A);

        // Randomized traffic with shifting write/read rates to reach full and empty
        for (int blk = 0; blk < 8; blk++) begin
            wp = (blk % 3 == 0) ? 85 : (blk % 3 == 1) ? 20 : 50;
            rp = (blk % 3 == 0) ? 20 : (blk % 3 == 1) ? 85 : 50;
            for (int i = 0; i < 400; i++) begin
                step(($urandom_range(0, 499) != 0),
                     ($urandom_range(0, 99) < wp),
                     ($urandom_range(0, 99) < rp),
                     DATA_W'($urandom), "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 128: number of storage entries, a power of two.
REQ-003 SHALL have port clk  input  1: the single clock; all logic is rising-edge triggered.
REQ-004 SHALL have port rst_  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port wrtEn  input  1: write request.
REQ-006 SHALL have port rdEn  input  1: read request.
REQ-007 SHALL have port wrtData  input  DATA_W: write data.
REQ-008 SHALL have port full  output  1: high when DEPTH entries are stored.
REQ-009 SHALL have port empty  output  1: high when zero entries are stored.
REQ-010 SHALL have port rdData  output  DATA_W: registered read data.

Function
REQ-011 SHALL accept a write on a clk edge when wrtEn=1 and the write is permitted; wrtData is stored at the write pointer, and the write pointer increments.
REQ-012 SHALL permit a write when full=0, or when full=1 and a read is accepted on the same edge.
REQ-013 SHALL accept a read on a clk edge when rdEn=1 and empty=0. The entry at the read pointer is loaded into rdData, and the read pointer increments.
REQ-014 SHALL have a read latency of exactly one cycle: rdData is valid after the edge that accepts the read.
REQ-015 SHALL hold rdData unchanged on every edge with no accepted read.
REQ-016 SHALL ignore a read while empty=1, even if a write is accepted on the same edge; that entry is readable from the next cycle.
REQ-017 SHALL ignore a write while full=1 with no accepted read: no state changes and the data is dropped.
REQ-018 SHALL use pointers of log2(DEPTH)+1 bits (8 bits at the default): the lower bits address memory, and the MSB is a wrap flag.
REQ-019 SHALL assert empty when the two pointers are equal.
REQ-020 SHALL assert full when the pointer address bits are equal and the wrap bits differ.
REQ-021 SHALL make full and empty registered or pointer-derived, with no combinational path from wrtEn or rdEn.
REQ-022 SHALL wrap both pointers modulo 2*DEPTH, so that wrap-around past entry DEPTH-1 to entry 0 is seamless.
REQ-023 SHALL, when a read and a write are both accepted on the same edge, leave the occupancy unchanged and leave full and empty unchanged.
REQ-024 SHALL preserve strict first-in, first-out ordering, with no data loss or duplication.

Reset
REQ-025 SHALL, on a clk edge with rst_=0, clear both pointers to 0, set empty=1, full=0 and rdData=0, regardless of wrtEn and rdEn.
REQ-026 SHALL discard stored contents on a reset in mid-operation; memory cells need not be cleared.
REQ-027 SHALL accept a write on the first edge with rst_=1.

Structure
REQ-028 SHALL place DATA_W, DEPTH and ADDR_W=$clog2(DEPTH) defaults in the shared package sync_fifo_pkg.
REQ-029 SHALL implement storage as one sub-module, fifo_mem, a simple dual-port RAM with one write port and one registered read port, with no reset on its array.
REQ-030 SHALL keep the pointer, flag and control logic in sync_fifo.

Verification
REQ-031 Reset: hold rst_=0 for 1 cycle -> empty=1, full=0, rdData=0.
REQ-032 Fill: write 1..128 on consecutive cycles -> full=1 after the 128th edge and empty=0 throughout; a 129th write of 0xFF is dropped.
REQ-033 Drain: rdEn=1 for 128 cycles -> rdData sequence 1..128 in order, empty=1 after the last read; a further read leaves rdData=128.
REQ-034 Simultaneous at full: wrtEn=rdEn=1 with wrtData=0xAA -> rdData=1, full stays 1; the final drained word is 0xAA.
REQ-035 Empty plus write plus read: with empty=1 and wrtEn=rdEn=1 on data 0x55 -> read ignored, empty=0 next cycle; the next read returns 0x55.
REQ-036 Wrap and reset: write 100, read 100, write 100 -> data in order across the pointer wrap; then rst_=0 mid-stream -> empty=1, full=0.
